// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a missing 8-word block from memory, steers each word into the data array, then commits the tag.
// CRITICAL_WORD_FIRST_EN starts the fill at the missing word, wraps within the block and adds critical_valid.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_W-1:0]     miss_address,
  input  logic                  memory_data_valid,
  input  logic [DATA_W-1:0]     memory_data_in,
  output logic                  fsm_busy,
  output logic                  memory_req,
  output logic [ADDR_W-1:0]     memory_address,
  output logic                  write_data_array,
  output logic [2**IDX_W-1:0]   word_enable,
  output logic [DATA_W-1:0]     data_out,
  output logic                  write_tag_array
`ifdef CRITICAL_WORD_FIRST_EN
  ,
  output logic                  critical_valid
`endif
);
  localparam int BASE_W = ADDR_W - IDX_W - 1;
  localparam int WORDS = 2**IDX_W;
  localparam logic [WORDS-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, FILL, WRITE_TAG} state_t;
  state_t state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] offset_q, offset_d;
  logic [IDX_W:0] req_cnt_q, req_cnt_d, rcv_cnt_q, rcv_cnt_d;
  logic [IDX_W-1:0] widx_req, widx_rcv;
  logic unused_ok;
  assign unused_ok = ^{miss_address[0], offset_q};
`ifdef CRITICAL_WORD_FIRST_EN
  assign widx_req = offset_q + req_cnt_q[IDX_W-1:0];
  assign widx_rcv = offset_q + rcv_cnt_q[IDX_W-1:0];
  assign critical_valid = write_data_array && rcv_cnt_q == '0;
`else
  assign widx_req = req_cnt_q[IDX_W-1:0];
  assign widx_rcv = rcv_cnt_q[IDX_W-1:0];
`endif
  // Counter MSB set means all words of the block have been requested/received.
  always_comb begin
    fsm_busy = state_q != IDLE;
    memory_req = state_q == FILL && !req_cnt_q[IDX_W];
    memory_address = memory_req ? {base_q, widx_req, 1'b0} : '0;
    write_data_array = state_q == FILL && memory_data_valid && !rcv_cnt_q[IDX_W];
    word_enable = write_data_array ? ONE << widx_rcv : '0;
    data_out = memory_data_in;
    write_tag_array = state_q == WRITE_TAG;
    state_d = state_q;
    base_d = base_q;
    offset_d = offset_q;
    req_cnt_d = memory_req ? req_cnt_q + 1'b1 : req_cnt_q;
    rcv_cnt_d = write_data_array ? rcv_cnt_q + 1'b1 : rcv_cnt_q;
    if (state_q == IDLE && miss_detected) begin
      state_d = FILL;
      base_d = miss_address[ADDR_W-1:IDX_W+1];
      offset_d = miss_address[IDX_W:1];
      req_cnt_d = '0;
      rcv_cnt_d = '0;
    end
    if (state_q == FILL && rcv_cnt_d[IDX_W]) state_d = WRITE_TAG;
    if (state_q == WRITE_TAG) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q <= '0;
      offset_q <= '0;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      offset_q <= offset_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: queue-based reference model plus memory responder; directed fills then random traffic.
module tb_cache_fill_fsm;
  localparam int NT = 8192;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic memory_data_valid = 1'b0;
  logic [15:0] memory_data_in = 16'h0;
  logic fsm_busy, memory_req, write_data_array, write_tag_array;
  logic [15:0] memory_address, data_out;
  logic [7:0] word_enable;
`ifdef CRITICAL_WORD_FIRST_EN
  logic critical_valid;
`endif

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data_in(memory_data_in),
    .fsm_busy(fsm_busy), .memory_req(memory_req), .memory_address(memory_address),
    .write_data_array(write_data_array), .word_enable(word_enable), .data_out(data_out),
    .write_tag_array(write_tag_array)
`ifdef CRITICAL_WORD_FIRST_EN
    , .critical_valid(critical_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit cmp_en = 0;
  int lat_min = 4, lat_var = 0, gap_pct = 0, stray_pct = 0, gap_at = 0, n_del = 0, hold = 0;
  int rdy_q[$];
  int ph = 0;
  logic [15:0] m_addr_q[$];
  int m_widx_q[$];
  logic e_busy, e_req, e_wr, e_crit;
  logic [15:0] e_addr;
  logic [7:0] e_we;
  logic tr_busy [NT];
  logic tr_req [NT];
  logic tr_wr [NT];
  logic tr_tag [NT];
  logic tr_crit [NT];
  logic [15:0] tr_addr [NT];
  logic [7:0] tr_we [NT];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Reference model: a fill is a list of word addresses to request and word indices to receive.
  initial forever begin
    @(negedge clk);
    e_busy = ph != 0;
    e_req = ph == 1 && m_addr_q.size() > 0;
    e_addr = e_req ? m_addr_q[0] : 16'h0;
    e_wr = ph == 1 && memory_data_valid && m_widx_q.size() > 0;
    e_we = e_wr ? 8'h01 << m_widx_q[0] : 8'h00;
    e_crit = e_wr && m_widx_q.size() == 8;
    if (cmp_en) begin
      chk("fsm_busy", 32'(fsm_busy), 32'(e_busy));
      chk("memory_req", 32'(memory_req), 32'(e_req));
      chk("memory_address", 32'(memory_address), 32'(e_addr));
      chk("write_data_array", 32'(write_data_array), 32'(e_wr));
      chk("word_enable", 32'(word_enable), 32'(e_we));
      chk("write_tag_array", 32'(write_tag_array), 32'(ph == 2));
      if (e_wr) chk("data_out", 32'(data_out), 32'(memory_data_in));
`ifdef CRITICAL_WORD_FIRST_EN
      chk("critical_valid", 32'(critical_valid), 32'(e_crit));
`endif
    end
    if (cyc < NT) begin
      tr_busy[cyc] = fsm_busy;
      tr_req[cyc] = memory_req;
      tr_wr[cyc] = write_data_array;
      tr_tag[cyc] = write_tag_array;
      tr_addr[cyc] = memory_address;
      tr_we[cyc] = word_enable;
`ifdef CRITICAL_WORD_FIRST_EN
      tr_crit[cyc] = critical_valid;
`else
      tr_crit[cyc] = e_crit;
`endif
    end
    if (!rst) rdy_q.delete();
    else if (memory_req === 1'b1) begin
      int r;
      r = cyc + lat_min + int'($urandom_range(lat_var, 0));
      if (rdy_q.size() > 0 && r < rdy_q[$]) r = rdy_q[$];
      rdy_q.push_back(r);
    end
    if (!rst) begin
      ph = 0;
      m_addr_q.delete();
      m_widx_q.delete();
    end else if (ph == 0) begin
      if (miss_detected) begin
        int off;
`ifdef CRITICAL_WORD_FIRST_EN
        off = int'(miss_address[3:1]);
`else
        off = 0;
`endif
        m_addr_q.delete();
        m_widx_q.delete();
        for (int k = 0; k < 8; k++) begin
          m_addr_q.push_back({miss_address[15:4], 4'h0} + 16'(2 * ((off + k) % 8)));
          m_widx_q.push_back((off + k) % 8);
        end
        ph = 1;
      end
    end else if (ph == 1) begin
      if (m_addr_q.size() > 0) void'(m_addr_q.pop_front());
      if (memory_data_valid && m_widx_q.size() > 0) begin
        void'(m_widx_q.pop_front());
        if (m_widx_q.size() == 0) ph = 2;
      end
    end else ph = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (hold > 0) begin
      hold--;
      memory_data_valid = 1'b0;
    end else if (rdy_q.size() > 0 && rdy_q[0] <= cyc && int'($urandom_range(99, 0)) >= gap_pct) begin
      memory_data_valid = 1'b1;
      void'(rdy_q.pop_front());
      n_del++;
      if (n_del == gap_at) hold = 3;
    end else memory_data_valid = int'($urandom_range(99, 0)) < stray_pct;
    memory_data_in = 16'($urandom);
  endtask

  int c0, c1;
  logic [15:0] exp_addr [8];
  logic [7:0] exp_we [8];
  logic [15:0] first_addr, last_addr;
  logic [7:0] first_we, fourth_we;

  initial begin
`ifdef CRITICAL_WORD_FIRST_EN
    exp_addr = '{16'h3A56, 16'h3A58, 16'h3A5A, 16'h3A5C, 16'h3A5E, 16'h3A50, 16'h3A52, 16'h3A54};
    exp_we = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
`else
    exp_addr = '{16'h3A50, 16'h3A52, 16'h3A54, 16'h3A56, 16'h3A58, 16'h3A5A, 16'h3A5C, 16'h3A5E};
    exp_we = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`endif
    first_addr = exp_addr[0];
    last_addr = exp_addr[7];
    first_we = exp_we[0];
    fourth_we = exp_we[3];
    rst = 1'b0;
    miss_detected = 1'b1;
    miss_address = 16'h3A56;
    tick();
    cmp_en = 1;
    tick();
    memory_data_valid = 1'b1;
    chk("reset_busy", 32'(fsm_busy), 32'h0);
    chk("reset_req", 32'(memory_req), 32'h0);
    chk("reset_addr", 32'(memory_address), 32'h0);
    chk("reset_tag", 32'(write_tag_array), 32'h0);
    tick();
    rst = 1'b1;
    c0 = cyc;
    tick();
    miss_detected = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    for (int k = 0; k < 8; k++) begin
      chk("basic_addr", 32'(tr_addr[c0 + 1 + k]), 32'(exp_addr[k]));
      chk("basic_we", 32'(tr_we[c0 + 5 + k]), 32'(exp_we[k]));
    end
    chk("basic_req_end", 32'(tr_req[c0 + 9]), 32'h0);
    chk("basic_wr_early", 32'(tr_wr[c0 + 4]), 32'h0);
    chk("basic_busy_first", 32'(tr_busy[c0 + 1]), 32'h1);
    chk("basic_tag_before", 32'(tr_tag[c0 + 12]), 32'h0);
    chk("basic_tag", 32'(tr_tag[c0 + 13]), 32'h1);
    chk("basic_busy_last", 32'(tr_busy[c0 + 13]), 32'h1);
    chk("basic_busy_end", 32'(tr_busy[c0 + 14]), 32'h0);
`ifdef CRITICAL_WORD_FIRST_EN
    chk("critical_first", 32'(tr_crit[c0 + 5]), 32'h1);
    chk("critical_second", 32'(tr_crit[c0 + 6]), 32'h0);
`endif
    n_del = 0;
    gap_at = 3;
    tick();
    miss_detected = 1'b1;
    c0 = cyc;
    tick();
    miss_detected = 1'b0;
    for (int k = 0; k < 18; k++) tick();
    gap_at = 0;
    for (int k = 8; k <= 10; k++) chk("gap_no_write", 32'(tr_wr[c0 + k]), 32'h0);
    chk("gap_word4", 32'(tr_we[c0 + 11]), 32'(fourth_we));
    chk("gap_tag_early", 32'(tr_tag[c0 + 13]), 32'h0);
    chk("gap_tag", 32'(tr_tag[c0 + 16]), 32'h1);
    chk("gap_busy_end", 32'(tr_busy[c0 + 17]), 32'h0);
    tick();
    memory_data_valid = 1'b1;
    c1 = cyc;
    tick();
    memory_data_valid = 1'b1;
    chk("stray_idle_wr", 32'(tr_wr[c1]), 32'h0);
    chk("stray_idle_we", 32'(tr_we[c1]), 32'h0);
    tick();
    miss_detected = 1'b1;
    miss_address = 16'h3A56;
    c0 = cyc;
    for (int k = 1; k <= 14; k++) begin
      tick();
      miss_detected = k < 14 && k % 2 == 1;
      miss_address = 16'hFFFE;
      if (k >= 13) memory_data_valid = 1'b1;
    end
    tick();
    tick();
    chk("ignore_last_addr", 32'(tr_addr[c0 + 8]), 32'(last_addr));
    chk("ignore_tag", 32'(tr_tag[c0 + 13]), 32'h1);
    chk("ignore_tag_wr", 32'(tr_wr[c0 + 13]), 32'h0);
    chk("ignore_idle_wr", 32'(tr_wr[c0 + 14]), 32'h0);
    chk("ignore_busy", 32'(tr_busy[c0 + 14]), 32'h0);
    chk("ignore_busy_next", 32'(tr_busy[c0 + 15]), 32'h0);
    miss_address = 16'h3A56;
    tick();
    miss_detected = 1'b1;
    c0 = cyc;
    tick();
    miss_detected = 1'b0;
    for (int k = 2; k <= 8; k++) tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    miss_detected = 1'b1;
    c1 = cyc;
    tick();
    miss_detected = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("abort_4th_word", 32'(tr_wr[c0 + 8]), 32'h1);
    chk("abort_busy", 32'(tr_busy[c0 + 10]), 32'h0);
    chk("abort_req", 32'(tr_req[c0 + 10]), 32'h0);
    chk("abort_no_tag", 32'(tr_tag[c0 + 10]), 32'h0);
    chk("abort_no_tag2", 32'(tr_tag[c0 + 11]), 32'h0);
    chk("restart_addr", 32'(tr_addr[c1 + 1]), 32'(first_addr));
    chk("restart_we", 32'(tr_we[c1 + 5]), 32'(first_we));
    chk("restart_tag", 32'(tr_tag[c1 + 13]), 32'h1);
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) begin
        lat_min = 1 + int'($urandom_range(4, 0));
        lat_var = int'($urandom_range(3, 0));
        gap_pct = int'($urandom_range(40, 0));
        stray_pct = ($urandom_range(1, 0) == 1) ? 10 : 0;
      end
      tick();
      rst = int'($urandom_range(99, 0)) >= 1;
      miss_detected = int'($urandom_range(99, 0)) < 30;
      miss_address = 16'($urandom);
    end
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
